n64_cmd_rx: RTL and testbench
=============================

N64_CMD_RX -- requirements
Module: n64_cmd_rx

Interface
REQ-001 SHALL have parameter SAMPLES_PER_BIT, default 4, sample_clk cycles per 1 us line bit-time; legal values are 4 or more.
REQ-002 SHALL have parameter DATA_BYTES, default 32, write-command payload length in bytes; legal values are 1 or more.
REQ-003 SHALL have parameter TIMEOUT_SAMPLES, default 3*SAMPLES_PER_BIT, the mid-frame idle-high abort threshold.
REQ-004 sample_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 rx_enable  input  1  high while the console owns the line; low means ignore the line.
REQ-007 data_rx  input  1  raw, asynchronous open-drain line; idles high.
REQ-008 cmd  output  8  last received command byte.
REQ-009 address  output  16  address field of a read or write command, stored as received.
REQ-010 crc  output  8  running payload CRC.
REQ-011 addr_crc_ok  output  1  address checksum matched.
REQ-012 buf_we / buf_waddr / buf_wdata  output  1 / clog2(DATA_BYTES) / 8  payload byte write port.
REQ-013 tx_handoff  output  1  one-cycle pulse: frame complete, transmitter may respond.
REQ-014 frame_err  output  1  one-cycle pulse: malformed frame aborted.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 data_rx SHALL pass through a 2-flop synchronizer; all following rules refer to the synchronized line.
REQ-017 Each falling edge SHALL clear a sample counter; bit value SHALL be the line level at counter == SAMPLES_PER_BIT/2, so high reads 1 and low reads 0.
REQ-018 States: IDLE, CMD, ADDR, DATA, STOP, ARM; bits SHALL be received MSB-first within each byte.
REQ-019 IDLE -> CMD on a falling edge while rx_enable=1 and armed.
REQ-020 CMD: after 8 bits, cmd is updated, then:
- 0x00, 0x01, 0xFF -> STOP.
- 0x02, 0x03 -> ADDR.
- any other value -> ARM, with no handoff and no error.
REQ-021 ADDR: 16 bits SHALL be shifted into address; next state is STOP for 0x02 and DATA for 0x03.
REQ-022 DATA: buf_we SHALL pulse for one cycle after each 8th bit, with buf_waddr counting 0..DATA_BYTES-1 and buf_wdata holding that byte; after DATA_BYTES bytes the next state is STOP.
REQ-023 crc: cleared on entry to DATA, then updated per DATA bit; 8-bit CRC, poly 0x85 (x^8+x^7+x^2+1), MSB-first.
REQ-024 STOP: a sampled 1 SHALL pulse tx_handoff in the following cycle and go to ARM; a sampled 0 SHALL pulse frame_err and go to ARM.
REQ-025 Mid-frame (CMD/ADDR/DATA/STOP), line high for TIMEOUT_SAMPLES consecutive cycles SHALL pulse frame_err and go to ARM.
REQ-026 rx_enable falling mid-frame SHALL go to ARM with no frame_err and no handoff; all outputs hold their values.
REQ-027 ARM -> IDLE once the line has been high for SAMPLES_PER_BIT consecutive cycles.
REQ-028 cmd, address and crc SHALL hold their values until overwritten by the next frame.

Reset
REQ-029 While reset=1, the next edge SHALL apply:
- state = ARM
- cmd = 8'hFE
- address = 16'h0000, crc = 8'h00
- addr_crc_ok = 0, buf_we = 0, buf_waddr = 0
- tx_handoff = 0, frame_err = 0, busy = 0
- synchronizer flops = 1
REQ-030 Reset mid-frame SHALL discard the partial frame with no pulses; decoding resumes per REQ-027.

Configuration
REQ-031 Macro N64_RX_ADDR_CRC_CHECK_EN defined: 5-bit CRC, poly 0x15, init 0, over address[15:5] MSB-first, compared to address[4:0].
- addr_crc_ok is valid from the cycle after the 16th address bit.
- addr_crc_ok clears at each CMD entry.
- A mismatch does not block tx_handoff.
REQ-032 N64_RX_ADDR_CRC_CHECK_EN undefined: no checksum logic; addr_crc_ok SHALL be 1 outside reset.

Verification (SAMPLES_PER_BIT=4, DATA_BYTES=32)
REQ-033 Frame 0x01 + stop -> cmd=0x01, one tx_handoff pulse, no buf_we, no frame_err.
REQ-034 0x03, address with valid checksum, 32 bytes 0x00..0x1F, stop -> 32 buf_we pulses, waddr 0..31 = wdata, handoff pulse, addr_crc_ok=1.
REQ-035 0x03 with all-zero payload -> crc=8'h00; with all-0xFF payload -> crc equal to the bench model value.
REQ-036 0x02 then line held high 12 cycles after address bit 5 -> one frame_err pulse, no handoff, busy falls.
REQ-037 Reset asserted at DATA bit 100 -> outputs at reset values next cycle; following 0x00 frame decodes with one handoff.
REQ-038 Bad address checksum: macro defined -> addr_crc_ok=0 and handoff pulses; macro undefined -> addr_crc_ok=1. Unknown cmd 0x55 -> neither pulse.

Source files
------------

// File: rtl/n64_cmd_rx_if.sv
// n64_cmd_rx_if: the console line inputs and the decoded command/payload
// outputs of the N64 command receiver.
// The master side is the receiver and the slave side is its user.
`timescale 1ns/1ps

interface n64_cmd_rx_if #(
  parameter int DATA_BYTES = 32
) ();
  localparam int AW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  logic          rx_enable;
  logic          data_rx;
  logic [7:0]    cmd;
  logic [15:0]   address;
  logic [7:0]    crc;
  logic          addr_crc_ok;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [7:0]    buf_wdata;
  logic          tx_handoff;
  logic          frame_err;
  logic          busy;

  modport master (
    input  rx_enable, data_rx,
    output cmd, address, crc, addr_crc_ok, buf_we, buf_waddr, buf_wdata,
           tx_handoff, frame_err, busy
  );

  modport slave (
    output rx_enable, data_rx,
    input  cmd, address, crc, addr_crc_ok, buf_we, buf_waddr, buf_wdata,
           tx_handoff, frame_err, busy
  );
endinterface

// File: rtl/n64_cmd_rx.sv
// n64_cmd_rx: oversampling receiver for console-to-controller N64 frames.
// It decodes the command byte, the 16-bit address and the write payload,
// and then signals a handoff to the transmitter once the stop bit is seen.
// Optional macro N64_RX_ADDR_CRC_CHECK_EN adds the 5-bit address checksum
// compare. Without the macro, addr_crc_ok stays high outside reset.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | armed, waiting for the first falling edge of a frame
// CMD   | shifting the 8-bit command
// ADDR  | shifting the 16-bit address (commands 0x02 / 0x03)
// DATA  | shifting DATA_BYTES payload bytes (command 0x03)
// STOP  | sampling the stop bit
// ARM   | waiting for the line to idle high before re-arming
`timescale 1ns/1ps

module n64_cmd_rx #(
  parameter int SAMPLES_PER_BIT = 4,
  parameter int DATA_BYTES      = 32,
  parameter int TIMEOUT_SAMPLES = 3 * SAMPLES_PER_BIT
) (
  input  logic         sample_clk,
  input  logic         reset,
  n64_cmd_rx_if.master bus
);

  localparam int AW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int CW = $clog2(SAMPLES_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_SAMPLES + 1);
  localparam int RW = $clog2(SAMPLES_PER_BIT);

  localparam logic [CW-1:0] SMP_MID  = CW'(SAMPLES_PER_BIT / 2);
  localparam logic [CW-1:0] SMP_SAT  = CW'(SAMPLES_PER_BIT);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_SAMPLES - 1);
  localparam logic [RW-1:0] ARM_LOAD = RW'(SAMPLES_PER_BIT - 1);
  localparam logic [AW-1:0] LAST_BYTE = AW'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_STOP, S_ARM
  } state_t;

  state_t state, state_nxt;

  logic          sync_q1, sync_q2, line_d;
  logic          line, fall, strobe, timeout, arm_done;
  logic [CW-1:0] smp_cnt;
  logic [TW-1:0] hi_tmr;
  logic [RW-1:0] arm_tmr;

  logic          take_bit, handoff_nxt, err_nxt, we_nxt;
  logic [7:0]    sh, sh_shift;
  logic [15:0]   addr_shift;
  logic [3:0]    bit_cnt;
  logic [AW-1:0] byte_cnt;

  logic [7:0]    cmd_q, crc_q, wdata_q;
  logic [15:0]   addr_q;
  logic [AW-1:0] waddr_q;
  logic          crc_ok_q, we_q, handoff_q, err_q, busy_q;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h85 : 8'h00);
  endfunction

`ifdef N64_RX_ADDR_CRC_CHECK_EN
  function automatic logic [4:0] addr_crc5(input logic [10:0] d);
    logic [4:0] c;
    logic       fb;
    c = '0;
    for (int i = 10; i >= 0; i--) begin
      fb = c[4] ^ d[i];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h15 : 5'h00);
    end
    return c;
  endfunction
`endif

  assign line       = sync_q2;
  assign fall       = line_d & ~line;
  // smp_cnt counts samples since the latest falling edge; the edge cycle
  // itself is sample zero, so the register is reloaded with one.
  assign strobe     = ~fall && (smp_cnt == SMP_MID);
  assign timeout    = line && (hi_tmr == '0);
  assign arm_done   = line && (arm_tmr == '0);
  assign sh_shift   = {sh[6:0], line};
  assign addr_shift = {addr_q[14:0], line};

  // Synchronise the raw line, detect falling edges and time the bit cell.
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      line_d  <= 1'b1;
      smp_cnt <= SMP_SAT;
    end else begin
      sync_q1 <= bus.data_rx;
      sync_q2 <= sync_q1;
      line_d  <= sync_q2;
      if (fall)
        smp_cnt <= CW'(1);
      else if (smp_cnt != SMP_SAT)
        smp_cnt <= smp_cnt + CW'(1);
    end
  end

  // High-run timers: mid-frame abort threshold and the re-arm idle time.
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      hi_tmr  <= TO_LOAD;
      arm_tmr <= ARM_LOAD;
    end else if (!line) begin
      hi_tmr  <= TO_LOAD;
      arm_tmr <= ARM_LOAD;
    end else begin
      if (hi_tmr != '0)  hi_tmr  <= hi_tmr - TW'(1);
      if (arm_tmr != '0) arm_tmr <= arm_tmr - RW'(1);
    end
  end

  // State register.
  always_ff @(posedge sample_clk) begin
    if (reset) state <= S_ARM;
    else       state <= state_nxt;
  end

  // Next-state decode and the one-cycle pulse requests.
  always_comb begin
    state_nxt   = state;
    take_bit    = 1'b0;
    handoff_nxt = 1'b0;
    err_nxt     = 1'b0;
    we_nxt      = 1'b0;
    case (state)
      S_IDLE: if (bus.rx_enable && fall) state_nxt = S_CMD;
      S_ARM:  if (arm_done) state_nxt = S_IDLE;
      S_CMD, S_ADDR, S_DATA, S_STOP: begin
        if (!bus.rx_enable) begin
          state_nxt = S_ARM;
        end else if (timeout) begin
          err_nxt   = 1'b1;
          state_nxt = S_ARM;
        end else if (strobe) begin
          take_bit = 1'b1;
          case (state)
            S_CMD: begin
              if (bit_cnt == 4'd7) begin
                case (sh_shift)
                  8'h00, 8'h01, 8'hFF: state_nxt = S_STOP;
                  8'h02, 8'h03:        state_nxt = S_ADDR;
                  default:             state_nxt = S_ARM;
                endcase
              end
            end
            S_ADDR: begin
              if (bit_cnt == 4'd15)
                state_nxt = (cmd_q == 8'h03) ? S_DATA : S_STOP;
            end
            S_DATA: begin
              if (bit_cnt == 4'd7) begin
                we_nxt = 1'b1;
                if (byte_cnt == LAST_BYTE) state_nxt = S_STOP;
              end
            end
            S_STOP: begin
              if (line) handoff_nxt = 1'b1;
              else      err_nxt     = 1'b1;
              state_nxt = S_ARM;
            end
            default: ;
          endcase
        end
      end
      default: state_nxt = S_ARM;
    endcase
  end

  // Field shifting, payload write port, CRCs and registered pulses.
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      cmd_q     <= 8'hFE;
      addr_q    <= '0;
      crc_q     <= '0;
      crc_ok_q  <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      handoff_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      sh        <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
    end else begin
      handoff_q <= handoff_nxt;
      err_q     <= err_nxt;
      we_q      <= we_nxt;
      busy_q    <= (state_nxt != S_IDLE);
`ifndef N64_RX_ADDR_CRC_CHECK_EN
      crc_ok_q  <= 1'b1;
`endif
      if (state == S_IDLE && state_nxt == S_CMD) begin
        bit_cnt <= '0;
`ifdef N64_RX_ADDR_CRC_CHECK_EN
        crc_ok_q <= 1'b0;
`endif
      end
      if (take_bit) begin
        sh      <= sh_shift;
        bit_cnt <= bit_cnt + 4'd1;
        case (state)
          S_CMD: begin
            if (bit_cnt == 4'd7) begin
              cmd_q   <= sh_shift;
              bit_cnt <= '0;
            end
          end
          S_ADDR: begin
            addr_q <= addr_shift;
            if (bit_cnt == 4'd15) begin
              bit_cnt  <= '0;
              byte_cnt <= '0;
              if (state_nxt == S_DATA) crc_q <= '0;
`ifdef N64_RX_ADDR_CRC_CHECK_EN
              crc_ok_q <= (addr_crc5(addr_shift[15:5]) == addr_shift[4:0]);
`endif
            end
          end
          S_DATA: begin
            crc_q <= crc8_step(crc_q, line);
            if (bit_cnt == 4'd7) begin
              bit_cnt  <= '0;
              wdata_q  <= sh_shift;
              waddr_q  <= byte_cnt;
              byte_cnt <= byte_cnt + AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.cmd         = cmd_q;
  assign bus.address     = addr_q;
  assign bus.crc         = crc_q;
  assign bus.addr_crc_ok = crc_ok_q;
  assign bus.buf_we      = we_q;
  assign bus.buf_waddr   = waddr_q;
  assign bus.buf_wdata   = wdata_q;
  assign bus.tx_handoff  = handoff_q;
  assign bus.frame_err   = err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_n64_cmd_rx.sv
// tb_n64_cmd_rx: drives N64 line-coded frames into n64_cmd_rx and
// checks the payload writes and the handoff/error pulses against queued
// expectations. Register outputs are checked after each frame.
`timescale 1ns/1ps

module tb_n64_cmd_rx;
  localparam int SPB = 4;
  localparam int DB  = 32;
`ifdef N64_RX_ADDR_CRC_CHECK_EN
  localparam bit ADDR_CHK = 1'b1;
`else
  localparam bit ADDR_CHK = 1'b0;
`endif
  localparam logic [1:0] EV_HANDOFF = 2'b10;
  localparam logic [1:0] EV_ERR     = 2'b01;

  logic sample_clk = 1'b0;
  logic reset      = 1'b1;

  n64_cmd_rx_if #(.DATA_BYTES(DB)) bus ();

  n64_cmd_rx #(.SAMPLES_PER_BIT(SPB), .DATA_BYTES(DB)) dut (
    .sample_clk (sample_clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 sample_clk = ~sample_clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [13:0] we_exp_q[$];
  logic [1:0]  evt_exp_q[$];
  logic [13:0] mon_we_exp;
  logic [1:0]  mon_evt_exp;
  logic [7:0]  crc_exp;
  logic [15:0] a_good, a_bad;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h85) : (r << 1);
    return r;
  endfunction

  // Remainder of hi * x^5 modulo x^5+x^4+x^2+1 by long division.
  function automatic logic [4:0] addr_sum(input logic [10:0] hi);
    logic [15:0] v;
    v = {hi, 5'b0};
    for (int i = 15; i >= 5; i--) if (v[i]) v = v ^ (16'h0035 << (i - 5));
    return v[4:0];
  endfunction

  // Scoreboard: every write and every pulse must match the queued expectation.
  always @(negedge sample_clk) begin
    if (!reset) begin
      if (bus.buf_we) begin
        mon_we_exp = (we_exp_q.size() != 0) ? we_exp_q.pop_front() : 14'h0;
        chk_val("buf_write", {1'b1, bus.buf_waddr, bus.buf_wdata}, mon_we_exp);
      end
      if (bus.tx_handoff || bus.frame_err) begin
        mon_evt_exp = (evt_exp_q.size() != 0) ? evt_exp_q.pop_front() : 2'b00;
        chk_val("pulse", {bus.tx_handoff, bus.frame_err}, mon_evt_exp);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic drive(input logic v, input int n);
    bus.data_rx = v;
    repeat (n) @(posedge sample_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    drive(1'b0, b ? SPB / 4 : 3 * SPB / 4);
    drive(1'b1, b ? 3 * SPB / 4 : SPB / 4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_stop();
    send_bit(1'b1);
    drive(1'b1, 24);
  endtask

  task automatic end_frame(input string tag);
    chk_val({tag, "_writes_left"}, we_exp_q.size(), 0);
    chk_val({tag, "_pulses_left"}, evt_exp_q.size(), 0);
  endtask

  task automatic send_write_frame(input logic [15:0] a, input int mode);
    logic [7:0] b;
    send_byte(8'h03);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    crc_exp = 8'h00;
    for (int i = 0; i < DB; i++) begin
      b = (mode == 0) ? 8'(i) : ((mode == 1) ? 8'h00 : 8'hFF);
      we_exp_q.push_back({1'b1, 5'(i), b});
      crc_exp = crc_byte(crc_exp, b);
      send_byte(b);
    end
    evt_exp_q.push_back(EV_HANDOFF);
    send_stop();
  endtask

  task automatic check_reset_values(input string tag);
    chk_val({tag, "_cmd"}, bus.cmd, 8'hFE);
    chk_val({tag, "_address"}, bus.address, 16'h0000);
    chk_val({tag, "_crc"}, bus.crc, 8'h00);
    chk_val({tag, "_addr_crc_ok"}, bus.addr_crc_ok, 0);
    chk_val({tag, "_buf_we"}, bus.buf_we, 0);
    chk_val({tag, "_buf_waddr"}, bus.buf_waddr, 0);
    chk_val({tag, "_tx_handoff"}, bus.tx_handoff, 0);
    chk_val({tag, "_frame_err"}, bus.frame_err, 0);
    chk_val({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    bus.rx_enable = 1'b1;
    bus.data_rx   = 1'b1;
    a_good = {11'h2A5, addr_sum(11'h2A5)};
    a_bad  = a_good ^ 16'h0001;

    @(posedge sample_clk);
    @(negedge sample_clk);
    check_reset_values("reset");
    @(posedge sample_clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 20);
    chk_val("idle_addr_crc_ok", bus.addr_crc_ok, {31'b0, ~ADDR_CHK});

    // Status command: no payload, one handoff.
    evt_exp_q.push_back(EV_HANDOFF);
    send_byte(8'h01);
    send_stop();
    chk_val("status_cmd", bus.cmd, 8'h01);
    chk_val("status_busy", bus.busy, 0);
    end_frame("status");

    // Write with incrementing payload and a valid address checksum.
    send_write_frame(a_good, 0);
    chk_val("write_cmd", bus.cmd, 8'h03);
    chk_val("write_address", bus.address, a_good);
    chk_val("write_addr_crc_ok", bus.addr_crc_ok, 1);
    chk_val("write_crc_inc", bus.crc, crc_exp);
    end_frame("write_inc");

    send_write_frame(a_good, 1);
    chk_val("write_crc_zero", bus.crc, 8'h00);
    end_frame("write_zero");

    send_write_frame(a_good, 2);
    chk_val("write_crc_ff", bus.crc, crc_exp);
    end_frame("write_ff");

    // Read command stalls high after five address bits.
    evt_exp_q.push_back(EV_ERR);
    send_byte(8'h02);
    for (int i = 15; i >= 11; i--) send_bit(a_good[i]);
    drive(1'b1, 12);
    for (int k = 0; k < 40 && bus.busy; k++) @(negedge sample_clk);
    chk_val("timeout_busy", bus.busy, 0);
    drive(1'b1, 8);
    end_frame("timeout");

    // Reset in the middle of the 101st payload bit.
    send_byte(8'h03);
    send_byte(a_good[15:8]);
    send_byte(a_good[7:0]);
    for (int i = 0; i < 12; i++) begin
      we_exp_q.push_back({1'b1, 5'(i), 8'hA0 + 8'(i)});
      send_byte(8'hA0 + 8'(i));
    end
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    bus.data_rx = 1'b0;
    reset = 1'b1;
    @(posedge sample_clk);
    @(negedge sample_clk);
    check_reset_values("midreset");
    @(posedge sample_clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 20);
    end_frame("midreset");
    evt_exp_q.push_back(EV_HANDOFF);
    send_byte(8'h00);
    send_stop();
    chk_val("after_reset_cmd", bus.cmd, 8'h00);
    end_frame("after_reset");

    // Read with a corrupted address checksum still hands off.
    evt_exp_q.push_back(EV_HANDOFF);
    send_byte(8'h02);
    send_byte(a_bad[15:8]);
    send_byte(a_bad[7:0]);
    send_stop();
    chk_val("bad_sum_address", bus.address, a_bad);
    chk_val("bad_sum_addr_crc_ok", bus.addr_crc_ok, {31'b0, ~ADDR_CHK});
    end_frame("bad_sum");

    // Unknown command: no pulse of either kind.
    send_byte(8'h55);
    send_stop();
    chk_val("unknown_cmd", bus.cmd, 8'h55);
    end_frame("unknown");

    // Console releases the line during the payload.
    send_byte(8'h03);
    send_byte(a_good[15:8]);
    send_byte(a_good[7:0]);
    we_exp_q.push_back({1'b1, 5'd0, 8'h5A});
    send_byte(8'h5A);
    send_bit(1'b1);
    send_bit(1'b0);
    bus.rx_enable = 1'b0;
    drive(1'b1, 20);
    bus.rx_enable = 1'b1;
    chk_val("disable_cmd", bus.cmd, 8'h03);
    chk_val("disable_busy", bus.busy, 0);
    end_frame("disable");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
